// File: rtl/radio86_pkg.sv
// Radio-86RK bus: shared memory-map constants and select encoding.
// Imported by the decoder, the bus sequencer and the debugger.
package radio86_pkg;

  localparam logic [15:0] RAM_TOP   = 16'h7FFF;
  localparam logic [15:0] PPI0_BASE = 16'h8000;
  localparam logic [15:0] PPI1_BASE = 16'hA000;
  localparam logic [15:0] CRTC_BASE = 16'hC000;
  localparam logic [15:0] DMA_BASE  = 16'hE000;
  localparam logic [15:0] ROM_BASE  = 16'hF800;

  localparam int DIV_MIN = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_IO0,
    SEL_IO1,
    SEL_IO2,
    SEL_IO3,
    SEL_ROM
  } sel_t;

endpackage

// File: rtl/radio86_decode.sv
// Radio-86RK address decoder: CPU address to target select and
// one-hot I/O window chip select.
module radio86_decode
  import radio86_pkg::*;
(
  input  logic [15:0] cpu_address,
  output sel_t        sel,
  output logic [3:0]  io_cs
);

  always_comb begin
    sel   = SEL_RAM;
    io_cs = 4'b0000;
    unique case (1'b1)
      cpu_address <= RAM_TOP: begin
        sel = SEL_RAM;
      end
      cpu_address >= PPI0_BASE &&
      cpu_address <  PPI1_BASE: begin
        sel   = SEL_IO0;
        io_cs = 4'b0001;
      end
      cpu_address >= PPI1_BASE &&
      cpu_address <  CRTC_BASE: begin
        sel   = SEL_IO1;
        io_cs = 4'b0010;
      end
      cpu_address >= CRTC_BASE &&
      cpu_address <  DMA_BASE: begin
        sel   = SEL_IO2;
        io_cs = 4'b0100;
      end
      cpu_address >= DMA_BASE &&
      cpu_address <  ROM_BASE: begin
        sel   = SEL_IO3;
        io_cs = 4'b1000;
      end
      cpu_address >= ROM_BASE: begin
        sel = SEL_ROM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/radio86_bus.sv
// Radio-86RK CPU bus sequencer: slot timing, CPU enable, read
// capture, single write commit and interleaved video-DMA reads.
module radio86_bus
  import radio86_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int ROM_AW = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              halt,
  input  logic [15:0]       cpu_address,
  input  logic [7:0]        cpu_out,
  input  logic              cpu_we,
  output logic [7:0]        cpu_in,
  output logic              cpu_ce,
  output logic [14:0]       ram_address,
  input  logic [7:0]        ram_in,
  output logic [7:0]        ram_out,
  output logic              ram_we,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [7:0]        rom_in,
  output logic [3:0]        io_cs,
  output logic [1:0]        io_address,
  input  logic [7:0]        io_in,
  output logic [7:0]        io_out,
  output logic              io_we,
  input  logic              dma_req,
  input  logic [14:0]       dma_addr,
  output logic              dma_ack,
  output logic [7:0]        dma_data
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_RD   = PW'(1);
  localparam logic [PW-1:0] PH_DMA  = PW'(DIV - 2);
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

  if (DIV < DIV_MIN || DIV > 64) begin : g_bad_div
    $error("radio86_bus: DIV out of range");
  end

  logic [PW-1:0] ph;
  logic          pend;
  logic          last;
  logic          dma_slot;
  logic [7:0]    rd_mux;
  sel_t          sel;

  radio86_decode u_decode (
    .cpu_address (cpu_address),
    .sel         (sel),
    .io_cs       (io_cs)
  );

  assign last     = (ph == PH_LAST);
  assign dma_slot = (ph == PH_DMA) && dma_req;

  // Writes are only strobed in the enable clock, so a held
  // cpu_we commits once per T-state, never twice.
  assign cpu_ce = reset_n & last & ~halt;
  assign ram_we = cpu_ce & cpu_we & (sel == SEL_RAM);
  assign io_we  = cpu_ce & cpu_we & (|io_cs);

  assign ram_address = dma_slot ? dma_addr
                                : cpu_address[14:0];
  assign ram_out     = cpu_out;
  assign io_out      = cpu_out;
  assign io_address  = cpu_address[1:0];
  assign rom_address = cpu_address[ROM_AW-1:0];

  always_comb begin
    rd_mux = io_in;
    unique case (sel)
      SEL_RAM: rd_mux = ram_in;
      SEL_ROM: rd_mux = rom_in;
      default: rd_mux = io_in;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ph       <= '0;
      pend     <= 1'b0;
      cpu_in   <= 8'h00;
      dma_ack  <= 1'b0;
      dma_data <= 8'h00;
    end else begin
      ph      <= last ? '0 : ph + PW'(1);
      dma_ack <= last & pend;
      if (last)
        pend <= 1'b0;
      else if (dma_slot)
        pend <= 1'b1;
      if (last && pend)
        dma_data <= ram_in;
      if (ph == PH_RD)
        cpu_in <= rd_mux;
    end
  end

endmodule

// File: tb/tb_radio86_bus.sv
// Self-checking bench for radio86_bus: behavioural slot model,
// per-cycle compare and directed scenario checks.
module tb_radio86_bus;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        halt;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic        cpu_ce;
  logic [14:0] ram_address;
  logic [7:0]  ram_in;
  logic [7:0]  ram_out;
  logic        ram_we;
  logic [10:0] rom_address;
  logic [7:0]  rom_in;
  logic [3:0]  io_cs;
  logic [1:0]  io_address;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        io_we;
  logic        dma_req;
  logic [14:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_data;

  radio86_bus #(.DIV(DIV), .ROM_AW(11)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .halt        (halt),
    .cpu_address (cpu_address),
    .cpu_out     (cpu_out),
    .cpu_we      (cpu_we),
    .cpu_in      (cpu_in),
    .cpu_ce      (cpu_ce),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .ram_we      (ram_we),
    .rom_address (rom_address),
    .rom_in      (rom_in),
    .io_cs       (io_cs),
    .io_address  (io_address),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_we       (io_we),
    .dma_req     (dma_req),
    .dma_addr    (dma_addr),
    .dma_ack     (dma_ack),
    .dma_data    (dma_data)
  );

  always #5 clock = ~clock;

  // Environment: synchronous RAM/ROM and an I/O device whose read
  // byte encodes the window and register it was addressed with.
  logic [7:0] ram [0:32767];
  logic [7:0] rom [0:2047];

  always @(posedge clock) begin
    if (ram_we) ram[ram_address] <= ram_out;
    ram_in <= ram[ram_address];
    rom_in <= rom[rom_address];
    io_in  <= {io_cs, 2'b00, io_address};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cs_of(input logic [15:0] a);
    if (a >= 16'h8000 && a < 16'hA000) return 4'b0001;
    if (a >= 16'hA000 && a < 16'hC000) return 4'b0010;
    if (a >= 16'hC000 && a < 16'hE000) return 4'b0100;
    if (a >= 16'hE000 && a < 16'hF800) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [7:0] src_of(input logic [15:0] a);
    if (a < 16'h8000)  return ram[a[14:0]];
    if (a >= 16'hF800) return rom[a[10:0]];
    return {cs_of(a), 2'b00, a[1:0]};
  endfunction

  // Model: t counts clocks since reset release; slot phase = t % DIV.
  int         t = 0;
  bit         started = 0;
  logic [7:0] exp_cpu_in;
  logic       exp_ack;
  logic [7:0] exp_dd;
  bit         pend;
  logic [7:0] pend_data;

  always @(posedge clock) begin
    started = 1;
    if (!reset_n) begin
      t = 0;
      exp_cpu_in = 8'h00;
      exp_ack = 1'b0;
      exp_dd = 8'h00;
      pend = 0;
    end else begin
      exp_ack = 1'b0;
      if (t % DIV == 1) exp_cpu_in = src_of(cpu_address);
      if (t % DIV == DIV - 1 && pend) begin
        exp_ack = 1'b1;
        exp_dd = pend_data;
        pend = 0;
      end
      if (t % DIV == DIV - 2 && dma_req) begin
        pend = 1;
        pend_data = ram[dma_addr];
      end
      t++;
    end
  end

  int ce_cnt = 0, ram_we_cnt = 0, io_we_cnt = 0, ack_cnt = 0;
  int first_ce_t = -1;
  logic [3:0] last_cs;
  logic [1:0] last_ioa;

  always @(negedge clock) begin
    int  ph;
    logic ece;
    logic [14:0] era;
    if (started) begin
      ph  = t % DIV;
      ece = reset_n && ph == DIV - 1 && !halt;
      era = (ph == DIV - 2 && dma_req) ? dma_addr
                                       : cpu_address[14:0];
      chk("cpu_ce", cpu_ce, ece);
      chk("ram_we", ram_we,
          ece && cpu_we && cpu_address < 16'h8000);
      chk("io_we", io_we,
          ece && cpu_we && cs_of(cpu_address) != 0);
      chk("io_cs", io_cs, cs_of(cpu_address));
      chk("io_address", io_address, cpu_address[1:0]);
      chk("rom_address", rom_address, cpu_address[10:0]);
      chk("ram_out", ram_out, cpu_out);
      chk("io_out", io_out, cpu_out);
      chk("ram_address", ram_address, era);
      chk("cpu_in", cpu_in, exp_cpu_in);
      chk("dma_ack", dma_ack, exp_ack);
      chk("dma_data", dma_data, exp_dd);
      if (cpu_ce) ce_cnt++;
      if (ram_we) ram_we_cnt++;
      if (io_we) begin
        io_we_cnt++;
        last_cs  = io_cs;
        last_ioa = io_address;
      end
      if (dma_ack) ack_cnt++;
      if (cpu_ce && first_ce_t < 0) first_ce_t = t;
    end
  end

  task automatic wait_phase(input int p);
    int guard = 0;
    @(negedge clock);
    while (t % DIV != p && guard < 4 * DIV) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 4 * DIV) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase %0d not reached", p);
    end
    #1;
  endtask

  task automatic clr();
    ce_cnt = 0;
    ram_we_cnt = 0;
    io_we_cnt = 0;
    ack_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom[i] = 8'(i) ^ 8'h3C;
    rom[0] = 8'hC3;
    ram[15'h0100] = 8'hA7;

    reset_n = 1'b0;
    halt = 1'b0;
    cpu_address = 16'h0000;
    cpu_out = 8'h00;
    cpu_we = 1'b0;
    dma_req = 1'b0;
    dma_addr = 15'h0000;
    repeat (3) @(negedge clock);
    chk("rst_cpu_ce", cpu_ce, 1'b0);
    chk("rst_cpu_in", cpu_in, 8'h00);
    chk("rst_dma_ack", dma_ack, 1'b0);
    #1 reset_n = 1'b1;

    // Idle
    repeat (3) wait_phase(0);
    chk("first_ce_clock", 16'(first_ce_t), 16'd3);
    chk("idle_ce_count", 16'(ce_cnt), 16'd3);
    chk("idle_we_count", 16'(ram_we_cnt + io_we_cnt), 16'd0);

    // Reads: ROM, RAM, I/O
    cpu_address = 16'hF800;
    repeat (2) @(negedge clock);
    chk("rom_read_ph2", cpu_in, 8'hC3);
    wait_phase(DIV - 1);
    chk("rom_read_at_ce", cpu_in, 8'hC3);
    wait_phase(0);
    cpu_address = 16'h0100;
    wait_phase(DIV - 1);
    chk("ram_read", cpu_in, 8'hA7);
    wait_phase(0);
    cpu_address = 16'h8002;
    wait_phase(DIV - 1);
    chk("io_read", cpu_in, 8'h12);
    wait_phase(0);

    // RAM write held three slots
    clr();
    cpu_address = 16'h7FFF;
    cpu_out = 8'h55;
    cpu_we = 1'b1;
    repeat (3) wait_phase(0);
    cpu_we = 1'b0;
    chk("wr_ram_we_count", 16'(ram_we_cnt), 16'd3);
    chk("wr_ce_count", 16'(ce_cnt), 16'd3);
    chk("ram_7fff", ram[15'h7FFF], 8'h55);

    // ROM write discarded
    clr();
    cpu_address = 16'hF900;
    cpu_out = 8'hAA;
    cpu_we = 1'b1;
    wait_phase(0);
    cpu_we = 1'b0;
    chk("rom_wr_strobes", 16'(ram_we_cnt + io_we_cnt), 16'd0);

    // DMA alongside a CPU write
    clr();
    dma_addr = 15'h0100;
    dma_req = 1'b1;
    cpu_address = 16'h0200;
    cpu_out = 8'h12;
    cpu_we = 1'b1;
    repeat (3) wait_phase(0);
    cpu_we = 1'b0;
    dma_req = 1'b0;
    chk("dma_ack_count", 16'(ack_cnt), 16'd3);
    chk("dma_data", dma_data, 8'hA7);
    chk("ram_0200", ram[15'h0200], 8'h12);

    // Halt during an I/O write, DMA keeps running
    clr();
    cpu_address = 16'hC001;
    cpu_out = 8'h5A;
    cpu_we = 1'b1;
    halt = 1'b1;
    dma_req = 1'b1;
    repeat (3) wait_phase(0);
    chk("halt_ce_count", 16'(ce_cnt), 16'd0);
    chk("halt_io_we_count", 16'(io_we_cnt), 16'd0);
    chk("halt_dma_acks", 16'(ack_cnt), 16'd3);
    halt = 1'b0;
    wait_phase(0);
    cpu_we = 1'b0;
    chk("post_halt_io_we", 16'(io_we_cnt), 16'd1);
    chk("post_halt_io_cs", last_cs, 4'b0100);
    chk("post_halt_io_addr", last_ioa, 2'b01);

    // Reset at DIV-2, then at DIV-1 with a DMA in flight
    for (int k = 0; k < 2; k++) begin
      wait_phase(DIV - 2 + k);
      reset_n = 1'b0;
      ack_cnt = 0;
      @(negedge clock);
      chk("mid_rst_cpu_ce", cpu_ce, 1'b0);
      chk("mid_rst_dma_ack", dma_ack, 1'b0);
      chk("mid_rst_cpu_in", cpu_in, 8'h00);
      chk("mid_rst_dma_data", dma_data, 8'h00);
      #1 reset_n = 1'b1;
      repeat (DIV - 1) @(negedge clock);
      chk("mid_rst_no_ack", 16'(ack_cnt), 16'd0);
    end
    dma_req = 1'b0;
    repeat (2) wait_phase(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
